// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int MAX_REQ = 16;
  localparam int IDX_W   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic logic [MAX_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [MAX_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // Lowest set bit wins if more than one bit is set.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin search: first requester at or after start_i, wrapping mod NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   start_i,
  output logic            found_o,
  output logic [IW-1:0]   winner_o
);

  // Walk the search order backwards so the earliest candidate overwrites later ones.
  always_comb begin
    found_o  = 1'b0;
    winner_o = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      logic [IW-1:0] idx_w;
      idx_w = IW'((int'(start_i) + k) % NREQ);
      if (req_i[idx_w]) begin
        found_o  = 1'b1;
        winner_o = idx_w;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between NREQ producers.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] din,
  input  logic                  full,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       gnt,
  output logic                  we,
  output logic [WIDTH-1:0]      datain,
  output logic                  busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

  // Handshake: requester i presents valid via req[i] with din stable;
  // ack[i] marks the cycle its word is written; req may drop before ack.

  arb_state_e      state_q;
  logic [NREQ-1:0] gnt_q;
  logic [IW-1:0]   last_q;
  logic [CW-1:0]   cnt_q;

  logic [IW-1:0]   start_d;
  logic            found_d;
  logic [IW-1:0]   winner_d;
  logic            owner_req;
  logic            burst_done;
  logic            release_d;

  // Both IDLE and release searches begin just after the previous owner.
  assign start_d = (last_q == IW'(NREQ - 1)) ? '0 : last_q + 1'b1;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req_i    (req),
    .start_i  (start_d),
    .found_o  (found_d),
    .winner_o (winner_d)
  );

  assign ack        = gnt_q & req & {NREQ{~full}};
  assign we         = |ack;
  assign owner_req  = |(gnt_q & req);
  assign burst_done = we && (cnt_q == CW'(BURST - 1));
  assign release_d  = (state_q == GRANT) && (burst_done || !owner_req);

  always_comb begin
    datain = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) datain = datain | din[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found_d) begin
            gnt_q   <= NREQ'(idx_to_onehot(IDX_W'(winner_d)));
            last_q  <= winner_d;
            cnt_q   <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (release_d) begin
            cnt_q <= '0;
            if (found_d) begin
              gnt_q  <= NREQ'(idx_to_onehot(IDX_W'(winner_d)));
              last_q <= winner_d;
            end else begin
              gnt_q   <= '0;
              state_q <= IDLE;
            end
          end else if (we) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign busy = (state_q == GRANT);

endmodule
